// File: rtl/pipeline_bus_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer / memory-bus arbiter.
package pipeline_bus_ctrl_pkg;

  localparam int unsigned STALL_W      = 6;
  localparam int unsigned STALL_EX_BIT = 3;

  typedef enum logic [1:0] {
    IDLE,
    IF_WAIT,
    MEM_WAIT
  } state_t;

  // Stall vector bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/pipeline_bus_ctrl_stall_encoder.sv
// Priority encoder turning stall sources into the stage stall vector and
// the EX-branch flush gate.
module stall_encoder
  import pipeline_bus_ctrl_pkg::*;
(
  input  logic               mem_busy,
  input  logic               ex_busy,
  input  logic               id_hazard,
  input  logic               if_busy,
  input  logic               flush_ex,
  output logic [STALL_W-1:0] stall,
  output logic               flush
);

  always_comb begin
    stall = STALL_NONE;
    if (mem_busy)       stall = STALL_MEM;
    else if (ex_busy)   stall = STALL_EX;
    else if (id_hazard) stall = STALL_ID;
    else if (if_busy)   stall = STALL_IF;
    flush = flush_ex & ~stall[STALL_EX_BIT];
  end

endmodule

// File: rtl/pipeline_bus_ctrl.sv
// Pipeline sequencer: arbitrates one single-port bus between fetch and
// load/store, with wait timeout, fetch drop on flush, and stall merging.
module pipeline_bus_ctrl
  import pipeline_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_valid,
  output logic [DATA_W-1:0]  if_rdata,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_valid,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic               bus_req,
  output logic               bus_we,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [DATA_W-1:0]  bus_wdata,
  input  logic               bus_ack,
  input  logic [DATA_W-1:0]  bus_rdata,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               flush_ex,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          drop;
  logic          last_mem;

  // A request whose valid is pulsing this cycle has just been served.
  logic if_pend, mem_pend, grant_mem, timed_out;
  assign if_pend   = if_req & ~if_valid;
  assign mem_pend  = mem_req & ~mem_valid;
  assign grant_mem = mem_pend & (~if_pend | ~last_mem);
  assign timed_out = (wait_cnt == CNT_LAST);

  stall_encoder u_stall_encoder (
    .mem_busy  (mem_pend & ~rst),
    .ex_busy   (stallreq_ex & ~rst),
    .id_hazard (stallreq_id & ~rst),
    .if_busy   (if_pend & ~rst),
    .flush_ex  (flush_ex & ~rst),
    .stall     (stall),
    .flush     (flush)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      drop      <= 1'b0;
      last_mem  <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      mem_valid <= 1'b0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      bus_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          drop     <= 1'b0;
          if (grant_mem) begin
            state     <= MEM_WAIT;
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            last_mem  <= 1'b1;
          end else if (if_pend) begin
            state    <= IF_WAIT;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= if_addr;
            last_mem <= 1'b0;
          end
        end
        IF_WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (flush) drop <= 1'b1;
          // A flush arriving in the completion cycle still drops the fetch.
          if (bus_ack || timed_out) begin
            if_rdata <= bus_ack ? bus_rdata : '0;
            if_valid <= ~(drop | flush);
            bus_err  <= ~bus_ack;
            bus_req  <= 1'b0;
            state    <= IDLE;
          end
        end
        MEM_WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (bus_ack || timed_out) begin
            mem_rdata <= bus_ack ? bus_rdata : '0;
            mem_valid <= 1'b1;
            bus_err   <= ~bus_ack;
            bus_req   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_bus_ctrl.sv
// Self-checking bench for pipeline_bus_ctrl: stall table, directed bus
// sequences and a randomized run against a transaction-level bus model.
module tb_pipeline_bus_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic        stallreq_id, stallreq_ex, flush_ex;
  logic        if_valid, mem_valid, bus_req, bus_we, flush, bus_err;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic [5:0]  stall;

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  pipeline_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .flush_ex(flush_ex),
    .stall(stall), .flush(flush), .bus_err(bus_err)
  );

  typedef struct {
    logic       mreq, ex, id, ireq, fex;
    logic [5:0] stall;
    logic       flush;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; mem_req = 0; mem_we = 0; bus_ack = 0;
    stallreq_id = 0; stallreq_ex = 0; flush_ex = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  // Acknowledge the current transfer immediately and check who gets valid.
  task automatic serve(input string tag, input bit exp_mem, input logic [31:0] exp_addr,
                       input logic [31:0] data);
    check({tag, "_bus_req"}, bus_req, 1);
    check({tag, "_bus_addr"}, bus_addr, exp_addr);
    bus_ack = 1; bus_rdata = data;
    tick();
    bus_ack = 0;
    check({tag, "_mem_valid"}, mem_valid, exp_mem);
    check({tag, "_if_valid"}, if_valid, !exp_mem);
  endtask

  // Stall rule: highest active source wins.
  function automatic logic [5:0] stall_ref(input bit m, input bit e, input bit i, input bit f);
    if (m) return 6'b011111;
    if (e) return 6'b001111;
    if (i) return 6'b000111;
    if (f) return 6'b000011;
    return 6'b000000;
  endfunction

  vec_t vecs [8];
  logic [31:0] smem [32];

  initial begin
    logic [31:0] a_m, a_i, if_a, mem_a, mem_d, exp_ifd, exp_memd;
    logic [5:0]  exp_s;
    logic [4:0]  idx;
    bit if_act, mem_act, mem_w, xfer_on, own_mem, drop, last_mem, prev_pi, prev_pm;
    bit done_prev, exp_ifv, exp_memv, exp_err, if_drop_done, exp_f, acked, exp_owner;
    int unsigned d, cnt;

    vecs[0] = '{0, 0, 0, 0, 0, 6'b000000, 0};
    vecs[1] = '{0, 0, 0, 1, 0, 6'b000011, 0};
    vecs[2] = '{0, 0, 1, 1, 1, 6'b000111, 1};
    vecs[3] = '{0, 1, 0, 0, 1, 6'b001111, 0};
    vecs[4] = '{1, 0, 0, 0, 0, 6'b011111, 0};
    vecs[5] = '{1, 1, 1, 1, 1, 6'b011111, 0};
    vecs[6] = '{0, 0, 0, 0, 1, 6'b000000, 1};
    vecs[7] = '{0, 1, 1, 0, 0, 6'b001111, 0};

    if_addr = 0; mem_addr = 0; mem_wdata = 0; bus_rdata = 0;
    do_reset();
    rst = 1;
    tick();
    check("rst_bus_req", bus_req, 0);
    check("rst_valids", {if_valid, mem_valid, bus_err}, 0);
    mem_req = 1; stallreq_ex = 1; flush_ex = 1;
    #1;
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    idle_inputs();
    rst = 0;
    tick();

    // Combinational stall/flush table; requests withdrawn before each edge.
    foreach (vecs[i]) begin
      mem_req = vecs[i].mreq; stallreq_ex = vecs[i].ex; stallreq_id = vecs[i].id;
      if_req = vecs[i].ireq; flush_ex = vecs[i].fex;
      #1;
      check($sformatf("tab%0d_stall", i), stall, vecs[i].stall);
      check($sformatf("tab%0d_flush", i), flush, vecs[i].flush);
      idle_inputs();
      tick();
    end

    // Load, ack on third wait cycle.
    mem_req = 1; mem_we = 0; mem_addr = 32'h100;
    #1;
    check("t1_stall_req", stall, 6'b011111);
    tick();
    for (int w = 1; w <= 3; w++) begin
      check($sformatf("t1_bus_req_w%0d", w), bus_req, 1);
      check("t1_bus_addr", bus_addr, 32'h100);
      check("t1_stall_wait", stall, 6'b011111);
      check("t1_no_valid", mem_valid, 0);
      bus_ack = (w == 3);
      bus_rdata = (w == 3) ? 32'hDEADBEEF : 32'h0;
      tick();
    end
    bus_ack = 0;
    check("t1_mem_valid", mem_valid, 1);
    check("t1_mem_rdata", mem_rdata, 32'hDEADBEEF);
    check("t1_bus_req_drop", bus_req, 0);
    check("t1_stall_release", stall, 0);
    mem_req = 0;
    tick();
    check("t1_valid_pulse", mem_valid, 0);

    // Store with no ack: timeout abort clears previously loaded rdata.
    mem_req = 1; mem_we = 1; mem_addr = 32'h400; mem_wdata = 32'h12345678;
    tick();
    for (int w = 1; w <= 4; w++) begin
      check($sformatf("t4_bus_req_w%0d", w), bus_req, 1);
      check("t4_bus_we", bus_we, 1);
      check("t4_bus_wdata", bus_wdata, 32'h12345678);
      check("t4_no_err", bus_err, 0);
      check("t4_stall", stall, 6'b011111);
      tick();
    end
    check("t4_bus_err", bus_err, 1);
    check("t4_mem_valid", mem_valid, 1);
    check("t4_mem_rdata", mem_rdata, 0);
    check("t4_bus_req_drop", bus_req, 0);
    check("t4_stall_release", stall, 0);
    mem_req = 0; mem_we = 0;
    tick();
    check("t4_err_pulse", bus_err, 0);

    // Ack coincides with the timeout cycle: ack wins.
    mem_req = 1; mem_addr = 32'h404;
    tick();
    for (int w = 1; w <= 4; w++) begin
      bus_ack = (w == 4);
      bus_rdata = 32'hCAFE0001;
      tick();
    end
    bus_ack = 0;
    check("tie_bus_err", bus_err, 0);
    check("tie_mem_valid", mem_valid, 1);
    check("tie_mem_rdata", mem_rdata, 32'hCAFE0001);
    mem_req = 0;
    tick();

    // Simultaneous requests after reset: MEM first, then alternation.
    do_reset();
    a_i = 32'h1000; a_m = 32'h2000;
    if_req = 1; if_addr = a_i; mem_req = 1; mem_addr = a_m;
    tick();
    for (int r = 0; r < 4; r++) begin
      serve($sformatf("t2_r%0d", r), (r % 2) == 0, (r % 2) == 0 ? a_m : a_i, 32'hA0 + r);
      if (r == 3) begin
        if_req = 0; mem_req = 0;
      end else if ((r % 2) == 0) begin
        a_m = a_m + 4; mem_addr = a_m;
      end else begin
        a_i = a_i + 4; if_addr = a_i;
      end
      tick();
    end
    check("t2_idle", bus_req, 0);
    mem_req = 1; a_m = a_m + 4; mem_addr = a_m;
    tick();
    serve("t2_solo", 1, a_m, 32'hB0);
    mem_req = 0;
    tick();
    // Last grant was MEM, so a fresh tie goes to IF.
    if_req = 1; a_i = a_i + 4; if_addr = a_i; mem_req = 1; mem_addr = a_m + 4;
    tick();
    serve("t2_fair", 0, a_i, 32'hB1);
    if_req = 0; mem_req = 0;
    tick();

    // Flush while a fetch is outstanding.
    do_reset();
    if_req = 1; if_addr = 32'h1100;
    #1;
    check("t3_stall_if", stall, 6'b000011);
    tick();
    check("t3_bus_req", bus_req, 1);
    flush_ex = 1;
    #1;
    check("t3_flush", flush, 1);
    tick();
    flush_ex = 0; bus_ack = 1; bus_rdata = 32'h55;
    tick();
    bus_ack = 0;
    check("t3_no_if_valid", if_valid, 0);
    check("t3_bus_req_drop", bus_req, 0);
    if_req = 0; mem_req = 1; mem_addr = 32'h300;
    tick();
    check("t3_if_valid_late", if_valid, 0);
    serve("t3_idle_grant", 1, 32'h300, 32'h77);
    mem_req = 0;
    tick();

    // Priority and flush gating.
    do_reset();
    stallreq_id = 1; stallreq_ex = 1; flush_ex = 1;
    #1;
    check("t5_stall_ex", stall, 6'b001111);
    check("t5_flush_gated_ex", flush, 0);
    mem_req = 1; mem_addr = 32'h500;
    #1;
    check("t5_stall_mem", stall, 6'b011111);
    check("t5_flush_gated_mem", flush, 0);
    idle_inputs();
    tick();

    // Reset in MEM_WAIT abandons the transfer.
    do_reset();
    mem_req = 1; mem_addr = 32'h600;
    tick();
    check("t6_bus_req", bus_req, 1);
    rst = 1;
    #1;
    check("t6_stall_in_rst", stall, 0);
    tick();
    check("t6_bus_req_rst", bus_req, 0);
    check("t6_stall_rst", stall, 0);
    rst = 0; mem_req = 0; bus_ack = 1; bus_rdata = 32'h66;
    tick();
    bus_ack = 0;
    check("t6_late_ack_1", mem_valid, 0);
    tick();
    check("t6_late_ack_2", mem_valid, 0);
    check("t6_bus_idle", bus_req, 0);

    // Randomized traffic against a transaction-level bus model.
    do_reset();
    foreach (smem[k]) smem[k] = $urandom;
    if_act = 0; mem_act = 0; mem_w = 0; if_a = 0; mem_a = 0; mem_d = 0;
    xfer_on = 0; own_mem = 0; drop = 0; last_mem = 0; prev_pi = 0; prev_pm = 0;
    done_prev = 0; exp_ifv = 0; exp_memv = 0; exp_err = 0; if_drop_done = 0;
    exp_ifd = 0; exp_memd = 0; d = 0; cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      check("rnd_if_valid", if_valid, exp_ifv);
      if (exp_ifv) check("rnd_if_rdata", if_rdata, exp_ifd);
      check("rnd_mem_valid", mem_valid, exp_memv);
      if (exp_memv) check("rnd_mem_rdata", mem_rdata, exp_memd);
      check("rnd_bus_err", bus_err, exp_err);
      if (done_prev) check("rnd_bus_req_drop", bus_req, 0);
      if (xfer_on) check("rnd_bus_req_held", bus_req, 1);

      if (exp_ifv || if_drop_done) if_act = 0;
      else if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1; if_a = 32'h1000 | ($urandom_range(0, 15) << 2);
      end
      if (exp_memv) mem_act = 0;
      else if (!mem_act && $urandom_range(0, 2) == 0) begin
        mem_act = 1; mem_a = 32'h2000 | ($urandom_range(0, 15) << 2);
        mem_w = $urandom_range(0, 1); mem_d = $urandom;
      end
      exp_ifv = 0; exp_memv = 0; exp_err = 0; if_drop_done = 0; done_prev = 0;
      if_req = if_act; if_addr = if_a;
      mem_req = mem_act; mem_addr = mem_a; mem_we = mem_w; mem_wdata = mem_d;
      stallreq_id = ($urandom_range(0, 3) == 0);
      stallreq_ex = ($urandom_range(0, 3) == 0);
      flush_ex = ($urandom_range(0, 3) == 0);
      #1;
      exp_s = stall_ref(mem_req && !mem_valid, stallreq_ex, stallreq_id, if_req && !if_valid);
      exp_f = flush_ex && !exp_s[3];
      check("rnd_stall", stall, exp_s);
      check("rnd_flush", flush, exp_f);

      bus_ack = 0; bus_rdata = $urandom;
      if (bus_req) begin
        if (!xfer_on) begin
          xfer_on = 1; cnt = 0; drop = 0; d = $urandom_range(1, 5);
          exp_owner = (prev_pi && prev_pm) ? !last_mem : prev_pm;
          own_mem = bus_addr[13];
          check("rnd_grant_owner", own_mem, exp_owner);
          last_mem = exp_owner;
        end
        check("rnd_bus_addr", bus_addr, own_mem ? mem_a : if_a);
        check("rnd_bus_we", bus_we, own_mem && mem_w);
        if (own_mem && mem_w) check("rnd_bus_wdata", bus_wdata, mem_d);
        if (!own_mem && exp_f) drop = 1;
        cnt++;
        if (cnt == d || cnt == TO) begin
          acked = (cnt == d);
          idx = {bus_addr[13], bus_addr[5:2]};
          if (acked) begin
            bus_ack = 1;
            if (own_mem && bus_we) smem[idx] = bus_wdata;
            else bus_rdata = smem[idx];
          end
          if (own_mem) begin
            exp_memv = 1; exp_memd = acked ? bus_rdata : 32'h0;
          end else if (drop) if_drop_done = 1;
          else begin
            exp_ifv = 1; exp_ifd = acked ? bus_rdata : 32'h0;
          end
          exp_err = !acked;
          xfer_on = 0; done_prev = 1;
        end
      end
      prev_pi = if_act; prev_pm = mem_act;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
